pe_array_sequencer: RTL

Controller that configures and sequences a column of `NUM_PE` PE_E-style processing elements over their shared `PE_inst`/`init`/`run` interface. It accepts an instruction stream from the host over a valid/ready port and clears the PEs. It loads each PE's configuration buffer in turn, then issues run beats (with stall support) and reports completion once the last PE result register has settled. It sits between the host configuration path and the PE array and is the only driver of the PE control pins.

---
 rtl/pe_array_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pe_array_sequencer.sv
// Sequencer that clears, configures and runs a column of processing elements
// over their shared PE_inst/init/run control pins.
module pe_array_sequencer #(
    parameter int unsigned NUM_PE    = 4,
    parameter int unsigned INST_W    = 28,
    parameter int unsigned BUF_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [$clog2(BUF_DEPTH):0]  cfg_len,
    input  logic                        abort,
    input  logic                        stall,
    input  logic [INST_W-1:0]           inst_data,
    input  logic                        inst_valid,
    output logic                        inst_ready,
    output logic [INST_W-1:0]           pe_inst_o,
    output logic [NUM_PE-1:0]           init_o,
    output logic                        run_o,
    output logic                        pe_rst_o,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int unsigned LEN_W    = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned WORD_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned PE_IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic                  abort_q, abort_d;
    logic [LEN_W-1:0]      cfg_len_q, cfg_len_d;
    logic [PE_IDX_W-1:0]   pe_idx_q, pe_idx_d;
    logic [WORD_W-1:0]     word_idx_q, word_idx_d;
    logic [LEN_W-1:0]      run_cnt_q, run_cnt_d;
    logic [1:0]            drain_cnt_q, drain_cnt_d;

    logic [INST_W-1:0]     pe_inst_q, pe_inst_d;
    logic [NUM_PE-1:0]     init_q, init_d;
    logic                  run_q, run_d;
    logic                  pe_rst_q, pe_rst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  inst_ready_q, inst_ready_d;

    logic                  beat_c;
    logic                  last_word_c;
    logic                  last_pe_c;
    logic                  len_ok_c;

    // Handshake and sequencing qualifiers.
    always_comb begin
        beat_c      = inst_valid & inst_ready_q;
        last_word_c = (LEN_W'(word_idx_q) == (cfg_len_q - LEN_W'(1)));
        last_pe_c   = (pe_idx_q == PE_IDX_W'(NUM_PE - 1));
        len_ok_c    = (cfg_len != '0) && (cfg_len <= LEN_W'(BUF_DEPTH));
    end

    // Next-state, counter and output decode; abort overrides everything but IDLE.
    always_comb begin
        state_d      = state_q;
        abort_d      = abort_q;
        cfg_len_d    = cfg_len_q;
        pe_idx_d     = pe_idx_q;
        word_idx_d   = word_idx_q;
        run_cnt_d    = run_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        pe_inst_d    = '0;
        init_d       = '0;
        run_d        = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok_c) begin
                        cfg_len_d = cfg_len;
                        abort_d   = 1'b0;
                        state_d   = S_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                pe_idx_d    = '0;
                word_idx_d  = '0;
                run_cnt_d   = '0;
                drain_cnt_d = '0;
                abort_d     = 1'b0;
                state_d     = abort_q ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                if (beat_c) begin
                    pe_inst_d         = inst_data;
                    init_d[pe_idx_q]  = 1'b1;
                    if (last_word_c) begin
                        word_idx_d = '0;
                        if (last_pe_c) begin
                            state_d = S_RUN;
                        end else begin
                            pe_idx_d = pe_idx_q + PE_IDX_W'(1);
                        end
                    end else begin
                        word_idx_d = word_idx_q + WORD_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (!stall) begin
                    run_d     = 1'b1;
                    run_cnt_d = run_cnt_q + LEN_W'(1);
                    if ((run_cnt_q + LEN_W'(1)) == cfg_len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == 2'd2) begin
                    drain_cnt_d = '0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_CLEAR;
            abort_d    = 1'b1;
            pe_idx_d   = pe_idx_q;
            word_idx_d = word_idx_q;
            run_cnt_d  = run_cnt_q;
            pe_inst_d  = '0;
            init_d     = '0;
            run_d      = 1'b0;
            done_d     = 1'b0;
        end

        pe_rst_d     = (state_d == S_CLEAR);
        busy_d       = (state_d != S_IDLE);
        inst_ready_d = (state_d == S_LOAD);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            abort_q      <= 1'b0;
            cfg_len_q    <= '0;
            pe_idx_q     <= '0;
            word_idx_q   <= '0;
            run_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            pe_inst_q    <= '0;
            init_q       <= '0;
            run_q        <= 1'b0;
            pe_rst_q     <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            inst_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            abort_q      <= abort_d;
            cfg_len_q    <= cfg_len_d;
            pe_idx_q     <= pe_idx_d;
            word_idx_q   <= word_idx_d;
            run_cnt_q    <= run_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            pe_inst_q    <= pe_inst_d;
            init_q       <= init_d;
            run_q        <= run_d;
            pe_rst_q     <= pe_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            inst_ready_q <= inst_ready_d;
        end
    end

    // Output ports.
    always_comb begin
        inst_ready = inst_ready_q;
        pe_inst_o  = pe_inst_q;
        init_o     = init_q;
        run_o      = run_q;
        pe_rst_o   = pe_rst_q;
        busy       = busy_q;
        done       = done_q;
        err        = err_q;
    end

endmodule
